// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: register write codes and redirect FSM states.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    WR_ADV   = 2'b00,
    WR_FLUSH = 2'b01,
    WR_HOLD  = 2'b10
  } wr_ctrl_t;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; increments one cycle after inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline write-code generator and deferred-redirect FSM; codes are combinational,
// and a redirect that meets a busy fetch bus is parked until the bus drains.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  input  logic              mdu_busy,
  input  logic              load_use,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [1:0]        FWrite,
  output logic [1:0]        DWrite,
  output logic [1:0]        EWrite,
  output logic [1:0]        MWrite,
  output logic [1:0]        WWrite,
  output logic              pc_redirect_valid,
  output logic [ADDR_W-1:0] pc_redirect_target,
  output logic              redirect_pending,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redirect_cnt
);

  pctrl_state_t      r_state;
  pctrl_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_target_q;
  logic [ADDR_W-1:0] w_target_nxt;

  wr_ctrl_t          w_f, w_d, w_e, w_m, w_w;
  logic              w_pc_vld;
  logic [ADDR_W-1:0] w_pc_tgt;
  logic              w_stall_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= PC_RUN;
      r_target_q <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_target_q <= w_target_nxt;
    end
  end

  always_comb begin
    w_f          = WR_ADV;
    w_d          = WR_ADV;
    w_e          = WR_ADV;
    w_m          = WR_ADV;
    w_w          = WR_ADV;
    w_pc_vld     = 1'b0;
    w_pc_tgt     = r_target_q;
    w_state_nxt  = r_state;
    w_target_nxt = r_target_q;

    // Memory and MDU stalls outrank redirects: E stays held and re-presents it later.
    if (dmem_busy) begin
      w_f = WR_HOLD;
      w_d = WR_HOLD;
      w_e = WR_HOLD;
      w_m = WR_HOLD;
      w_w = WR_FLUSH;
    end else if (mdu_busy) begin
      w_f = WR_HOLD;
      w_d = WR_HOLD;
      w_e = WR_HOLD;
      w_m = WR_FLUSH;
    end else if (redirect_valid) begin
      w_f          = WR_FLUSH;
      w_d          = WR_FLUSH;
      w_e          = WR_FLUSH;
      if (r_state == PC_RUN) begin
        if (!imem_busy) begin
          w_pc_vld = 1'b1;
          w_pc_tgt = redirect_target;
        end else begin
          w_target_nxt = redirect_target;
          w_state_nxt  = PC_DRAIN;
        end
      end else begin
        w_target_nxt = redirect_target;
        if (!imem_busy) begin
          w_pc_tgt = redirect_target;
        end
      end
    end else if (load_use) begin
      w_f = WR_HOLD;
      w_d = WR_HOLD;
      w_e = WR_FLUSH;
    end else if (imem_busy) begin
      w_f = WR_FLUSH;
    end

    // The fetch in flight while draining is wrong-path; complete as soon as the bus is free.
    if (r_state == PC_DRAIN) begin
      if (!dmem_busy && !mdu_busy) begin
        w_f = WR_FLUSH;
      end
      if (!imem_busy) begin
        w_pc_vld    = 1'b1;
        w_state_nxt = PC_RUN;
      end
    end

    if (reset) begin
      w_f      = WR_FLUSH;
      w_d      = WR_FLUSH;
      w_e      = WR_FLUSH;
      w_m      = WR_FLUSH;
      w_w      = WR_FLUSH;
      w_pc_vld = 1'b0;
    end
  end

  assign w_stall_inc = (w_f != WR_ADV) && !reset;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pc_vld),
    .count (redirect_cnt)
  );

  assign FWrite             = w_f;
  assign DWrite             = w_d;
  assign EWrite             = w_e;
  assign MWrite             = w_m;
  assign WWrite             = w_w;
  assign pc_redirect_valid  = w_pc_vld;
  assign pc_redirect_target = w_pc_tgt;
  assign redirect_pending   = (r_state == PC_DRAIN);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl built with 4-bit counters so saturation is reachable.
module tb_pipe_ctrl;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_busy, dmem_busy, mdu_busy, load_use, redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic [1:0]        FWrite, DWrite, EWrite, MWrite, WWrite;
  logic              pc_redirect_valid;
  logic [ADDR_W-1:0] pc_redirect_target;
  logic              redirect_pending;
  logic [CNT_W-1:0]  stall_cnt, redirect_cnt;
  logic [9:0]        codes;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_busy          (imem_busy),
    .dmem_busy          (dmem_busy),
    .mdu_busy           (mdu_busy),
    .load_use           (load_use),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .FWrite             (FWrite),
    .DWrite             (DWrite),
    .EWrite             (EWrite),
    .MWrite             (MWrite),
    .WWrite             (WWrite),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target),
    .redirect_pending   (redirect_pending),
    .stall_cnt          (stall_cnt),
    .redirect_cnt       (redirect_cnt)
  );

  assign codes = {FWrite, DWrite, EWrite, MWrite, WWrite};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_busy = 0; dmem_busy = 0; mdu_busy = 0; load_use = 0; redirect_valid = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++; if (codes !== 10'b01_01_01_01_01) begin errors++; $display("FAIL reset codes: got %b want %b", codes, 10'b01_01_01_01_01); end
      checks++; if (stall_cnt !== 4'd0 || redirect_cnt !== 4'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d want 0/0", stall_cnt, redirect_cnt); end
      checks++; if (pc_redirect_valid !== 1'b0 || redirect_pending !== 1'b0) begin errors++; $display("FAIL reset flags: got pcv=%b pend=%b want 0/0", pc_redirect_valid, redirect_pending); end
    end
    step(); reset = 0; idle(); #1;
    checks++; if (codes !== 10'b00_00_00_00_00) begin errors++; $display("FAIL post-reset codes: got %b want %b", codes, 10'b0); end
    step(); #1;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL post-reset stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    step(); load_use = 1; #1;
    checks++; if (codes !== 10'b10_10_01_00_00) begin errors++; $display("FAIL load_use codes: got %b want %b", codes, 10'b10_10_01_00_00); end
    step(); idle(); #1;
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL load_use stall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_redirect_immediate();
    step(); redirect_valid = 1; redirect_target = 64'h8000_1000; #1;
    checks++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 64'h8000_1000) begin errors++; $display("FAIL imm redirect: got v=%b t=%h want 1/80001000", pc_redirect_valid, pc_redirect_target); end
    checks++; if (codes !== 10'b01_01_01_00_00) begin errors++; $display("FAIL imm codes: got %b want %b", codes, 10'b01_01_01_00_00); end
    step(); idle(); #1;
    checks++; if (redirect_cnt !== 4'd1 || redirect_pending !== 1'b0) begin errors++; $display("FAIL imm after: got cnt=%0d pend=%b want 1/0", redirect_cnt, redirect_pending); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL imm stall_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_deferred();
    step(); redirect_valid = 1; redirect_target = 64'h8000_2000; imem_busy = 1; #1;
    checks++; if (pc_redirect_valid !== 1'b0 || codes !== 10'b01_01_01_00_00) begin errors++; $display("FAIL defer entry: got pcv=%b codes=%b want 0/%b", pc_redirect_valid, codes, 10'b01_01_01_00_00); end
    for (int i = 0; i < 3; i++) begin
      step(); redirect_valid = 0; imem_busy = 1; #1;
      checks++; if (redirect_pending !== 1'b1 || pc_redirect_valid !== 1'b0 || codes !== 10'b01_00_00_00_00) begin errors++; $display("FAIL defer wait %0d: got pend=%b pcv=%b codes=%b want 1/0/%b", i, redirect_pending, pc_redirect_valid, codes, 10'b01_00_00_00_00); end
    end
    step(); imem_busy = 0; #1;
    checks++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 64'h8000_2000 || FWrite !== 2'b01) begin errors++; $display("FAIL defer apply: got v=%b t=%h F=%b want 1/80002000/01", pc_redirect_valid, pc_redirect_target, FWrite); end
    step(); idle(); #1;
    checks++; if (redirect_pending !== 1'b0 || redirect_cnt !== 4'd2 || stall_cnt !== 4'd7) begin errors++; $display("FAIL defer after: got pend=%b rc=%0d sc=%0d want 0/2/7", redirect_pending, redirect_cnt, stall_cnt); end
  endtask

  task automatic test_stall_redirect();
    for (int i = 0; i < 2; i++) begin
      step(); dmem_busy = 1; redirect_valid = 1; redirect_target = 64'h8000_3000; #1;
      checks++; if (codes !== 10'b10_10_10_10_01 || pc_redirect_valid !== 1'b0) begin errors++; $display("FAIL dmem+redirect %0d: got codes=%b pcv=%b want %b/0", i, codes, pc_redirect_valid, 10'b10_10_10_10_01); end
    end
    step(); dmem_busy = 0; #1;
    checks++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 64'h8000_3000 || codes !== 10'b01_01_01_00_00) begin errors++; $display("FAIL dmem release: got v=%b t=%h codes=%b want 1/80003000/%b", pc_redirect_valid, pc_redirect_target, codes, 10'b01_01_01_00_00); end
    step(); idle(); #1;
    checks++; if (redirect_cnt !== 4'd3 || stall_cnt !== 4'd10) begin errors++; $display("FAIL dmem counters: got rc=%0d sc=%0d want 3/10", redirect_cnt, stall_cnt); end
  endtask

  task automatic test_mdu();
    step(); mdu_busy = 1; #1;
    checks++; if (codes !== 10'b10_10_10_01_00) begin errors++; $display("FAIL mdu codes: got %b want %b", codes, 10'b10_10_10_01_00); end
    step(); idle(); #1;
    checks++; if (stall_cnt !== 4'd11) begin errors++; $display("FAIL mdu stall_cnt: got %0d want 11", stall_cnt); end
  endtask

  task automatic test_drain_same_cycle();
    step(); redirect_valid = 1; redirect_target = 64'h8000_4000; imem_busy = 1; #1;
    step(); redirect_target = 64'h8000_4100; #1;
    checks++; if (redirect_pending !== 1'b1 || pc_redirect_valid !== 1'b0 || pc_redirect_target !== 64'h8000_4000) begin errors++; $display("FAIL drain overwrite: got pend=%b v=%b t=%h want 1/0/80004000", redirect_pending, pc_redirect_valid, pc_redirect_target); end
    step(); redirect_target = 64'h8000_4200; imem_busy = 0; #1;
    checks++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 64'h8000_4200 || codes !== 10'b01_01_01_00_00) begin errors++; $display("FAIL drain same-cycle: got v=%b t=%h codes=%b want 1/80004200/%b", pc_redirect_valid, pc_redirect_target, codes, 10'b01_01_01_00_00); end
    step(); idle(); #1;
    checks++; if (redirect_pending !== 1'b0 || redirect_cnt !== 4'd4 || stall_cnt !== 4'd14) begin errors++; $display("FAIL drain same-cycle after: got pend=%b rc=%0d sc=%0d want 0/4/14", redirect_pending, redirect_cnt, stall_cnt); end
  endtask

  task automatic test_drain_under_stall();
    step(); redirect_valid = 1; redirect_target = 64'h8000_5000; imem_busy = 1; #1;
    step(); redirect_valid = 0; imem_busy = 0; dmem_busy = 1; #1;
    checks++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 64'h8000_5000 || codes !== 10'b10_10_10_10_01) begin errors++; $display("FAIL drain under dmem: got v=%b t=%h codes=%b want 1/80005000/%b", pc_redirect_valid, pc_redirect_target, codes, 10'b10_10_10_10_01); end
    step(); idle(); #1;
    checks++; if (redirect_pending !== 1'b0 || redirect_cnt !== 4'd5 || stall_cnt !== 4'd15) begin errors++; $display("FAIL drain under dmem after: got pend=%b rc=%0d sc=%0d want 0/5/15", redirect_pending, redirect_cnt, stall_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    step(); redirect_valid = 1; redirect_target = 64'h8000_6000; imem_busy = 1; #1;
    step(); redirect_valid = 0; #1;
    checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL mid-drain pending: got %b want 1", redirect_pending); end
    #2 reset = 1; #1;
    checks++; if (redirect_pending !== 1'b0 || stall_cnt !== 4'd0 || redirect_cnt !== 4'd0 || codes !== 10'b01_01_01_01_01) begin errors++; $display("FAIL async reset: got pend=%b sc=%0d rc=%0d codes=%b want 0/0/0/%b", redirect_pending, stall_cnt, redirect_cnt, codes, 10'b01_01_01_01_01); end
    step(); reset = 0; idle(); #1;
    checks++; if (pc_redirect_valid !== 1'b0 || redirect_pending !== 1'b0 || codes !== 10'b0) begin errors++; $display("FAIL after mid-drain reset: got v=%b pend=%b codes=%b want 0/0/0", pc_redirect_valid, redirect_pending, codes); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      step(); load_use = 1; #1;
      if (i == 14) begin
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat approach: got %0d want 14", stall_cnt); end
      end
    end
    step(); #1;
    checks++; if (stall_cnt !== 4'hF || codes !== 10'b10_10_01_00_00) begin errors++; $display("FAIL saturation: got sc=%0d codes=%b want 15/%b", stall_cnt, codes, 10'b10_10_01_00_00); end
    step(); idle(); #1;
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL saturation hold: got %0d want 15", stall_cnt); end
  endtask

  initial begin
    reset = 1;
    idle();
    redirect_target = '0;
    test_reset();
    test_load_use();
    test_redirect_immediate();
    test_deferred();
    test_stall_redirect();
    test_mdu();
    test_drain_same_cycle();
    test_drain_under_stall();
    test_reset_mid_drain();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Each cycle it drives a 2-bit write code to every pipeline register (F, D, E, M, W), built from the hazard and busy inputs.
- It owns the deferred-redirect FSM: a mispredict or jump resolved in E while the instruction bus is mid-transaction is held until the bus drains.
- It also keeps stall and redirect performance counters.

Parameters:
- ADDR_W, 64, width of the redirect PC.
- CNT_W, 32, width of the performance counters (saturating).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- imem_busy  in  1  fetch is waiting on the instruction bus
- dmem_busy  in  1  M stage is waiting on the data bus
- mdu_busy  in  1  multi-cycle mul/div is occupying E
- load_use  in  1  instruction in D depends on a load in E
- redirect_valid  in  1  E resolved a taken or mispredicted control transfer
- redirect_target  in  ADDR_W  target PC for that transfer
- FWrite, DWrite, EWrite, MWrite, WWrite  out  2 each  pipeline register write codes
- pc_redirect_valid  out  1  PC register must load pc_redirect_target this cycle
- pc_redirect_target  out  ADDR_W  redirect PC
- redirect_pending  out  1  FSM is in DRAIN
- stall_cnt  out  CNT_W  count of cycles where FWrite != ADV
- redirect_cnt  out  CNT_W  count of redirects applied to the PC

Behaviour:
- Write codes: ADV=2'b00 loads the next value; FLUSH=2'b01 inserts a bubble; HOLD=2'b10 keeps the current value. The block never emits 2'b11.
- Reset (asynchronous, and held for as long as reset is high):
  - state=RUN, target_q=0, both counters=0.
  - All five write codes = FLUSH.
  - pc_redirect_valid=0, redirect_pending=0.
- State: RUN and DRAIN, plus target_q[ADDR_W].
- Write codes are combinational from state and inputs. The first matching rule wins:
  1. dmem_busy: F/D/E/M=HOLD, W=FLUSH.
  2. mdu_busy: F/D/E=HOLD, M=FLUSH, W=ADV.
  3. redirect_valid: D=FLUSH, E=FLUSH, M=ADV, W=ADV.
     - RUN with imem_busy=0: F=FLUSH, pc_redirect_valid=1, pc_redirect_target=redirect_target, redirect_cnt increments.
     - RUN with imem_busy=1: F=FLUSH, target_q<=redirect_target, next state DRAIN, no PC redirect this cycle.
     - DRAIN: target_q is overwritten (latest wins), state stays DRAIN.
  4. load_use: F/D=HOLD, E=FLUSH, M/W=ADV.
  5. imem_busy: F=FLUSH, D/E/M/W=ADV.
  6. Otherwise all ADV.
- Stalls take priority over redirects. While rule 1 or 2 holds, redirect_valid is ignored; E stays held and re-presents the redirect on a later cycle.
- DRAIN overrides:
  - FWrite is always FLUSH (in-flight fetch is wrong-path), except under rules 1 and 2, where it stays HOLD.
  - When imem_busy=0: pc_redirect_valid=1, pc_redirect_target=target_q, redirect_cnt increments, next state RUN. This happens in the same cycle regardless of the downstream stall rules.
  - A redirect arriving in the same cycle as the drain completes uses redirect_target instead of target_q, counts once, and returns to RUN.
- redirect_pending = (state==DRAIN).
- pc_redirect_target = redirect_target when acting directly in RUN, otherwise target_q.
- Counters saturate at all-ones and do not wrap. stall_cnt increments on every non-reset cycle where FWrite != ADV.
- Reset asserted mid-DRAIN: the pending redirect is discarded, FSM returns to RUN.

Decomposition:
- Shared pipes package:
  - wr_ctrl_t enum {WR_ADV, WR_FLUSH, WR_HOLD} as u2.
  - pctrl_state_t enum {PC_RUN, PC_DRAIN}.
  - Existing pipeline registers compare against these constants.
- One natural sub-module, sat_counter (parameter W, inputs clk/reset/inc, output count). It is instantiated twice.

Test Plan:
- Reset held 3 cycles, then released with all inputs low → during reset all codes 01 and counters 0; first cycle after release all codes 00, stall_cnt stays 0.
- load_use=1 for one cycle → F/D=10, E=01, M/W=00; stall_cnt=1.
- redirect_valid=1, redirect_target=0x8000_1000, imem_busy=0 → same cycle pc_redirect_valid=1, target 0x8000_1000, F/D/E=01; redirect_cnt=1; state stays RUN.
- redirect_valid=1, target=0x8000_2000, imem_busy=1 for 3 more cycles → redirect_pending=1, FWrite=01 each cycle, no PC redirect. In the cycle imem_busy falls: pc_redirect_valid=1 with 0x8000_2000, then redirect_pending=0.
- dmem_busy=1 and redirect_valid=1 together for 2 cycles, then dmem_busy=0 → first 2 cycles F/D/E/M=10, W=01, no redirect; third cycle the redirect is applied as in the immediate-redirect case.
- Force stall_cnt to all-ones (CNT_W=4 build) and hold load_use=1 → stall_cnt stays at 4'hF.
